// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit for the multicycle MIPS datapath.
// Radix-2 Booth multiply and restoring divide, one step per cycle, WIDTH steps per op.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multOP,
  input  logic             divOP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divByZero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FINISH
  } state_t;

  state_t r_state, w_next_state;

  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [WIDTH:0]   r_m;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [CW-1:0]    r_count;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_start_mul;
  logic             w_start_div;
  logic             w_div_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH:0]   w_b_mag;

  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_booth_acc;
  logic [WIDTH-1:0] w_booth_q;

  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH:0]   w_div_rem;
  logic [WIDTH-1:0] w_div_q;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  // FINISH accepts a new start exactly like IDLE, giving back-to-back operation.
  assign w_accept    = (r_state == S_IDLE) || (r_state == S_FINISH);
  assign w_start_mul = w_accept && multOP;
  assign w_start_div = w_accept && !multOP && divOP && (B != '0);
  assign w_div_zero  = w_accept && !multOP && divOP && (B == '0);
  assign w_last      = (r_count == CW'(WIDTH - 1));

  // Magnitudes as unsigned; |most-negative| still fits because it is read unsigned.
  assign w_a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign w_b_mag = {1'b0, (B[WIDTH-1] ? (~B + 1'b1) : B)};

  // Booth step; accumulator carries one guard bit so -M never overflows.
  always_comb begin
    w_booth_sum = r_acc;
    case ({r_q[0], r_q1})
      2'b01:   w_booth_sum = r_acc + r_m;
      2'b10:   w_booth_sum = r_acc - r_m;
      default: w_booth_sum = r_acc;
    endcase
    w_booth_acc = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
    w_booth_q   = {w_booth_sum[0], r_q[WIDTH-1:1]};
  end

  // Restoring divide step: r_acc is the partial remainder, r_q the dividend/quotient.
  always_comb begin
    w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    w_div_ge    = (w_div_shift >= r_m);
    w_div_rem   = w_div_ge ? (w_div_shift - r_m) : w_div_shift;
    w_div_q     = {r_q[WIDTH-2:0], w_div_ge};
    w_div_lo    = r_neg_q ? (~w_div_q + 1'b1) : w_div_q;
    w_div_hi    = r_neg_r ? (~w_div_rem[WIDTH-1:0] + 1'b1) : w_div_rem[WIDTH-1:0];
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE, S_FINISH: begin
        done         = (r_state == S_FINISH);
        w_next_state = S_IDLE;
        if (w_start_mul)      w_next_state = S_MULT;
        else if (w_start_div) w_next_state = S_DIV;
      end
      S_MULT: begin
        busy = 1'b1;
        if (w_last) w_next_state = S_FINISH;
      end
      S_DIV: begin
        busy = 1'b1;
        if (w_last) w_next_state = S_FINISH;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_count <= '0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next_state;
      r_dbz   <= w_div_zero;
      case (r_state)
        S_IDLE, S_FINISH: begin
          if (w_start_mul) begin
            r_acc   <= '0;
            r_q     <= B;
            r_q1    <= 1'b0;
            r_m     <= {A[WIDTH-1], A};
            r_count <= '0;
          end else if (w_start_div) begin
            r_acc   <= '0;
            r_q     <= w_a_mag;
            r_q1    <= 1'b0;
            r_m     <= w_b_mag;
            r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            r_neg_r <= A[WIDTH-1];
            r_count <= '0;
          end
        end
        S_MULT: begin
          r_acc   <= w_booth_acc;
          r_q     <= w_booth_q;
          r_q1    <= r_q[0];
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_hi <= w_booth_acc[WIDTH-1:0];
            r_lo <= w_booth_q;
          end
        end
        S_DIV: begin
          r_acc   <= w_div_rem;
          r_q     <= w_div_q;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign divByZero = r_dbz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             multOP;
  logic             divOP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             divByZero;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .multOP    (multOP),
    .divOP     (divOP),
    .A         (A),
    .B         (B),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // op: 0 = MULT, 1 = DIV, 2 = both strobes. inj: cycle at which a stray DIV is pulsed.
  task automatic run_op(input string tag, input int op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inj);
    int cyc;
    int busy_bad;
    int dbz_seen;
    multOP = (op != 1);
    divOP  = (op != 0);
    A      = a;
    B      = b;
    tick();
    multOP   = 1'b0;
    divOP    = 1'b0;
    cyc      = 1;
    busy_bad = 0;
    dbz_seen = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) busy_bad++;
      if (divByZero !== 1'b0) dbz_seen++;
      if (inj != 0 && cyc == inj) begin
        divOP = 1'b1;
        A     = 32'd5;
        B     = 32'd0;
      end else begin
        divOP = 1'b0;
      end
      tick();
      cyc++;
    end
    divOP = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'd33);
    check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    check({tag, "_dbz_run"}, 64'(dbz_seen), 64'd0);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_dbz_done"}, 64'(divByZero), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int seen;
    reset  = 1'b1;
    multOP = 1'b0;
    divOP  = 1'b0;
    A      = '0;
    B      = '0;
    tick();
    tick();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(divByZero), 64'd0);
    reset = 1'b0;
    tick();

    run_op("mul_7_m3", 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    tick();
    check("done_pulse", 64'(done), 64'd0);
    run_op("mul_maxpos", 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0);
    run_op("mul_minneg", 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
    run_op("div_m7_2", 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_100_m7", 1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 0);
    run_op("div_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
    tick();

    // Divide by zero: flag for one cycle, no busy, no done, hi/lo untouched.
    divOP = 1'b1;
    A     = 32'd5;
    B     = 32'd0;
    tick();
    divOP = 1'b0;
    check("dbz_flag", 64'(divByZero), 64'd1);
    check("dbz_busy", 64'(busy), 64'd0);
    check("dbz_done", 64'(done), 64'd0);
    tick();
    check("dbz_one_cycle", 64'(divByZero), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    check("dbz_no_done", 64'(seen), 64'd0);
    check("dbz_hi_hold", 64'(hi), 64'd0);
    check("dbz_lo_hold", 64'(lo), 64'h8000_0000);

    run_op("mul_inj", 0, 32'd1000, 32'd1000, 32'd0, 32'h000F_4240, 5);
    tick();
    run_op("both", 2, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
    tick();
    run_op("b2b_first", 0, 32'd3, 32'd4, 32'd0, 32'd12, 0);
    run_op("b2b_second", 0, 32'd5, 32'd6, 32'd0, 32'd30, 0);
    tick();

    // Reset in the middle of a divide aborts it and clears the results.
    divOP = 1'b1;
    A     = 32'd1000;
    B     = 32'd3;
    tick();
    divOP = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("mid_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    check("mid_rst_no_done", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
